// File: rtl/control_pkg.sv
// Shared definitions for the RV64I multi-cycle controller.
// Holds opcode/funct constants, the FSM state and instruction-class enums,
// the instruction/PC widths and the instruction classifier.
package control_pkg;

   localparam int INSTR_W = 32;
   localparam int PC_W    = 64;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;

   localparam logic [2:0] F3_ADD     = 3'b000;
   localparam logic [2:0] F3_DWORD   = 3'b011;

   localparam logic [6:0] F7_ADD     = 7'b0000000;
   localparam logic [6:0] F7_SUB     = 7'b0100000;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   // Instruction classes the controller distinguishes.
   typedef enum logic [2:0] {
      C_ILL  = 3'd0,
      C_ALU  = 3'd1,   // ADD / SUB
      C_ALUI = 3'd2,   // ADDI
      C_LD   = 3'd3,
      C_SD   = 3'd4
   } cls_t;

   function automatic cls_t classify(input logic [6:0] opcode,
                                     input logic [2:0] funct3,
                                     input logic [6:0] funct7);
      cls_t c;
      c = C_ILL;
      if (opcode == OPC_OP && funct3 == F3_ADD &&
          (funct7 == F7_ADD || funct7 == F7_SUB))
         c = C_ALU;
      else if (opcode == OPC_OP_IMM && funct3 == F3_ADD)
         c = C_ALUI;
      else if (opcode == OPC_LOAD && funct3 == F3_DWORD)
         c = C_LD;
      else if (opcode == OPC_STORE && funct3 == F3_DWORD)
         c = C_SD;
      return c;
   endfunction

endpackage

// File: rtl/control_unit_imm_gen.sv
// imm_gen: extracts the raw 12-bit immediate from an instruction word.
// Latency: purely combinational. Backpressure: none.
// Ports: opcode, instr_31_20 (instr[31:20]), instr_11_7 (instr[11:7]) in; imm out.
module imm_gen
   import control_pkg::*;
(
   input  logic [6:0]  opcode,
   input  logic [11:0] instr_31_20,
   input  logic [4:0]  instr_11_7,
   output logic [11:0] imm
);

   always_comb begin
      imm = '0;
      case (opcode)
         OPC_OP_IMM, OPC_LOAD: imm = instr_31_20;
         // S-type splits the immediate around the rs2/rs1 fields.
         OPC_STORE:            imm = {instr_31_20[11:5], instr_11_7};
         default:              imm = '0;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// control_unit: multi-cycle FETCH/DECODE/EXEC/MEM/WB controller for a
// subset of RV64I (ADD, SUB, ADDI, LD, SD).
// Latency: from accept edge k, ALU WE_RF at k+3, LD WE_RF at k+4, SD WE_MEM at k+2.
// Backpressure: instr_ready is high only in FETCH; instr_valid elsewhere is ignored.
// Ports: CLK/RST; instr_valid/instr/instr_ready handshake; pc; decoded
//        rs1/rs2/rd/immediate/sub/selects; WE_RF/WE_MEM strobes; illegal pulse.
module control_unit
   import control_pkg::*;
#(
   parameter logic [63:0] PC_RESET = 64'h0
)(
   input  logic        CLK,
   input  logic        RST,
   input  logic        instr_valid,
   input  logic [31:0] instr,
   output logic        instr_ready,
   output logic [63:0] pc,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [4:0]  rd,
   output logic [11:0] immediate,
   output logic        sub,
   output logic        WE_RF,
   output logic        WE_MEM,
   output logic        RF_din_sel,
   output logic        ULA_din2_sel,
   output logic        illegal
);

   state_t             state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [INSTR_W-1:0] ir_q, ir_d;
   logic [4:0]         rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
   logic [11:0]        imm_q, imm_d;
   logic               sub_q, sub_d;
   logic               rf_din_sel_q, rf_din_sel_d;
   logic               ula_din2_sel_q, ula_din2_sel_d;

   logic [11:0]        imm_in;
   cls_t               cls_in, cls_ir;

   // Decoded fields are captured straight from the word being latched into
   // the instruction register, so they are already valid throughout DECODE.
   imm_gen u_imm_gen (
      .opcode      (instr[6:0]),
      .instr_31_20 (instr[31:20]),
      .instr_11_7  (instr[11:7]),
      .imm         (imm_in)
   );

   assign cls_in = classify(instr[6:0], instr[14:12], instr[31:25]);
   assign cls_ir = classify(ir_q[6:0], ir_q[14:12], ir_q[31:25]);

   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      ir_d           = ir_q;
      rs1_d          = rs1_q;
      rs2_d          = rs2_q;
      rd_d           = rd_q;
      imm_d          = imm_q;
      sub_d          = sub_q;
      rf_din_sel_d   = rf_din_sel_q;
      ula_din2_sel_d = ula_din2_sel_q;
      instr_ready    = 1'b0;
      WE_RF          = 1'b0;
      WE_MEM         = 1'b0;
      illegal        = 1'b0;

      case (state_q)
         S_FETCH: begin
            instr_ready = 1'b1;
            if (instr_valid) begin
               ir_d           = instr;
               rs1_d          = instr[19:15];
               rs2_d          = instr[24:20];
               rd_d           = instr[11:7];
               imm_d          = imm_in;
               sub_d          = (cls_in == C_ALU) && instr[30];
               rf_din_sel_d   = (cls_in == C_ALU) || (cls_in == C_ALUI);
               ula_din2_sel_d = (cls_in == C_ALUI) || (cls_in == C_LD) ||
                                (cls_in == C_SD);
               state_d        = S_DECODE;
            end
         end
         S_DECODE: begin
            if (cls_ir == C_ILL) begin
               illegal = 1'b1;
               pc_d    = pc_q + 64'd4;
               state_d = S_FETCH;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (cls_ir == C_SD) begin
               WE_MEM  = 1'b1;
               pc_d    = pc_q + 64'd4;
               state_d = S_FETCH;
            end else if (cls_ir == C_LD) begin
               state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: state_d = S_WB;
         S_WB: begin
            // x0 is hard-wired zero, so writing it is suppressed.
            WE_RF   = (rd_q != 5'd0);
            pc_d    = pc_q + 64'd4;
            state_d = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q        <= S_FETCH;
         pc_q           <= PC_RESET;
         ir_q           <= '0;
         rs1_q          <= '0;
         rs2_q          <= '0;
         rd_q           <= '0;
         imm_q          <= '0;
         sub_q          <= 1'b0;
         rf_din_sel_q   <= 1'b0;
         ula_din2_sel_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         pc_q           <= pc_d;
         ir_q           <= ir_d;
         rs1_q          <= rs1_d;
         rs2_q          <= rs2_d;
         rd_q           <= rd_d;
         imm_q          <= imm_d;
         sub_q          <= sub_d;
         rf_din_sel_q   <= rf_din_sel_d;
         ula_din2_sel_q <= ula_din2_sel_d;
      end
   end

   assign pc           = pc_q;
   assign rs1          = rs1_q;
   assign rs2          = rs2_q;
   assign rd           = rd_q;
   assign immediate    = imm_q;
   assign sub          = sub_q;
   assign RF_din_sel   = rf_din_sel_q;
   assign ULA_din2_sel = ula_din2_sel_q;

endmodule
